// File: rtl/ex_stage.sv
// Execute stage: evaluates the ALU, resolves BEQ/JAL/JALR redirects and
// holds the result in a single-entry EX/MEM register with valid/ready flow control.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            alu_src_imm,
  input  logic            alu_src_pc,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_op_e;

  logic [XLEN-1:0] op_a, op_b, alu_res, br_target, jalr_target, result;
  logic            kill, illegal, zero, taken, jump, accept;

  always_comb begin
    op_a    = alu_src_pc  ? pc  : rs1_val;
    op_b    = alu_src_imm ? imm : rs2_val;
    alu_res = '0;
    kill    = 1'b0;
    illegal = 1'b0;
    case (alu_control)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_NOP: kill = 1'b1;
      default: begin
        kill    = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

  assign zero        = (alu_res == '0);
  assign taken       = is_branch & zero;
  assign jump        = is_jal | is_jalr;
  assign br_target   = pc + imm;
  assign jalr_target = {alu_res[XLEN-1:1], 1'b0};
  assign result      = jump ? (pc + XLEN'(4)) : alu_res;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_illegal    <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // redirect is tied to the accepting edge, so a held entry cannot re-fire it
      redirect <= accept & (taken | jump);
      if (accept && (taken || jump))
        redirect_pc <= is_jalr ? jalr_target : br_target;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid      <= 1'b1;
        out_result     <= result;
        out_store_data <= rs2_val;
        out_rd         <= rd;
        out_reg_write  <= reg_write & ~kill;
        out_mem_read   <= mem_read  & ~kill;
        out_mem_write  <= mem_write & ~kill;
        out_illegal    <= illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
